// File: rtl/icb_ext_sram_arbiter_pkg.sv
// Shared types for the MMA ICB ext arbiters: the icb_ext_* channel structs,
// the arbiter FSM encoding and the number of masters sharing one SRAM port.
package icb_ext_sram_arbiter_pkg;

    localparam int ICB_WIDTH  = 32;
    localparam int ICB_ADDR_W = 19;
    localparam int ICB_LEN_W  = 3;
    localparam int ICB_MW     = ICB_WIDTH / 8;
    localparam int ARB_NMST   = 2;

    // Master -> arbiter command channel.
    typedef struct packed {
        logic                  valid;
        logic [ICB_ADDR_W-1:0] addr;
        logic                  read;
        logic [ICB_LEN_W-1:0]  len;
    } icb_ext_cmd_m_t;

    // Arbiter -> master command ready.
    typedef struct packed {
        logic ready;
    } icb_ext_cmd_s_t;

    // Master -> arbiter write beat.
    typedef struct packed {
        logic                 w_valid;
        logic [ICB_WIDTH-1:0] wdata;
        logic [ICB_MW-1:0]    wmask;
    } icb_ext_wr_m_t;

    // Arbiter -> master write ready.
    typedef struct packed {
        logic w_ready;
    } icb_ext_wr_s_t;

    // Arbiter -> master response.
    typedef struct packed {
        logic                 rsp_valid;
        logic [ICB_WIDTH-1:0] rsp_rdata;
        logic                 rsp_err;
    } icb_ext_rsp_s_t;

    // Master -> arbiter response ready.
    typedef struct packed {
        logic rsp_ready;
    } icb_ext_rsp_m_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD   = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RSP   = 2'd3
    } arb_state_e;

    // True when a zero-based beat counter has reached the burst's last beat.
    // The counter is one bit wider than len so len=7 never wraps it.
    function automatic logic is_last_beat(input logic [ICB_LEN_W:0]   cnt,
                                          input logic [ICB_LEN_W-1:0] len);
        return cnt == {1'b0, len};
    endfunction

endpackage

// File: rtl/icb_ext_sram_arbiter_if.sv
// One ICB ext master port: command, write-beat and response channels.
// The master modport is the requesting unit, the slave modport the arbiter.
interface icb_ext_sram_arbiter_if;
    import icb_ext_sram_arbiter_pkg::*;

    icb_ext_cmd_m_t cmd_m;
    icb_ext_cmd_s_t cmd_s;
    icb_ext_wr_m_t  wr_m;
    icb_ext_wr_s_t  wr_s;
    icb_ext_rsp_s_t rsp_s;
    icb_ext_rsp_m_t rsp_m;

    modport master (
        output cmd_m,
        input  cmd_s,
        output wr_m,
        input  wr_s,
        input  rsp_s,
        output rsp_m
    );

    modport slave (
        input  cmd_m,
        output cmd_s,
        input  wr_m,
        output wr_s,
        output rsp_s,
        input  rsp_m
    );

endinterface

// File: rtl/icb_ext_sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie
// the master that was not granted last time wins. Purely combinational so
// the owning FSM decides when the pick is committed.
module icb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the request pair and the last-granted index.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/icb_ext_sram_arbiter.sv
// Shares one flat SRAM ICB port between two ICB ext masters. A grant covers
// a whole burst (command, write beats, responses); at most one burst is
// outstanding downstream. All beat paths are combinational pass-throughs
// gated by the FSM state and the current owner.
module icb_ext_sram_arbiter
    import icb_ext_sram_arbiter_pkg::*;
#(
    parameter int WIDTH  = ICB_WIDTH,
    parameter int ADDR_W = ICB_ADDR_W,
    parameter int LEN_W  = ICB_LEN_W,
    parameter int MW     = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    icb_ext_sram_arbiter_if.slave m0,
    icb_ext_sram_arbiter_if.slave m1,

    output logic                  sa_icb_cmd_valid,
    input  logic                  sa_icb_cmd_ready,
    output logic [ADDR_W-1:0]     sa_icb_cmd_addr,
    output logic                  sa_icb_cmd_read,
    output logic [LEN_W-1:0]      sa_icb_cmd_len,
    output logic [WIDTH-1:0]      sa_icb_cmd_wdata,
    output logic [MW-1:0]         sa_icb_cmd_wmask,
    output logic                  sa_icb_w_valid,
    input  logic                  sa_icb_w_ready,
    input  logic                  sa_icb_rsp_valid,
    output logic                  sa_icb_rsp_ready,
    input  logic [WIDTH-1:0]      sa_icb_rsp_rdata,
    input  logic                  sa_icb_rsp_err
);

    arb_state_e       state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             rr_last_reg, rr_last_next;
    logic [LEN_W:0]   beat_cnt_reg, beat_cnt_next;
    logic             is_read_reg, is_read_next;
    logic [LEN_W-1:0] len_q_reg, len_q_next;

    // Per-master views so the routing below can be written once per index.
    icb_ext_cmd_m_t cmd_m_arr [ARB_NMST];
    icb_ext_wr_m_t  wr_m_arr  [ARB_NMST];
    icb_ext_rsp_m_t rsp_m_arr [ARB_NMST];
    icb_ext_cmd_s_t cmd_s_arr [ARB_NMST];
    icb_ext_wr_s_t  wr_s_arr  [ARB_NMST];
    icb_ext_rsp_s_t rsp_s_arr [ARB_NMST];

    assign cmd_m_arr[0] = m0.cmd_m;
    assign cmd_m_arr[1] = m1.cmd_m;
    assign wr_m_arr[0]  = m0.wr_m;
    assign wr_m_arr[1]  = m1.wr_m;
    assign rsp_m_arr[0] = m0.rsp_m;
    assign rsp_m_arr[1] = m1.rsp_m;

    assign m0.cmd_s = cmd_s_arr[0];
    assign m1.cmd_s = cmd_s_arr[1];
    assign m0.wr_s  = wr_s_arr[0];
    assign m1.wr_s  = wr_s_arr[1];
    assign m0.rsp_s = rsp_s_arr[0];
    assign m1.rsp_s = rsp_s_arr[1];

    logic [ARB_NMST-1:0] req;
    logic [ARB_NMST-1:0] grant;

    genvar gi;
    generate
        for (gi = 0; gi < ARB_NMST; gi++) begin : g_req
            assign req[gi] = cmd_m_arr[gi].valid;
        end
    endgenerate

    icb_rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (rr_last_reg),
        .grant (grant)
    );

    // Owner's channels, selected by the registered owner index.
    icb_ext_cmd_m_t own_cmd;
    icb_ext_wr_m_t  own_wr;
    icb_ext_rsp_m_t own_rsp;

    assign own_cmd = cmd_m_arr[owner_reg];
    assign own_wr  = wr_m_arr[owner_reg];
    assign own_rsp = rsp_m_arr[owner_reg];

    // Upstream-facing return values before per-master gating.
    logic             up_cmd_ready;
    logic             up_w_ready;
    logic             up_rsp_valid;
    logic [WIDTH-1:0] up_rsp_rdata;
    logic             up_rsp_err;

    logic cmd_fire;
    logic w_fire;
    logic rsp_fire;

    assign cmd_fire = sa_icb_cmd_valid && sa_icb_cmd_ready;
    assign w_fire   = sa_icb_w_valid && sa_icb_w_ready;
    assign rsp_fire = sa_icb_rsp_valid && sa_icb_rsp_ready;

    // Next-state logic and the state/owner-gated pass-through muxes.
    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        rr_last_next     = rr_last_reg;
        beat_cnt_next    = beat_cnt_reg;
        is_read_next     = is_read_reg;
        len_q_next       = len_q_reg;

        sa_icb_cmd_valid = 1'b0;
        sa_icb_cmd_addr  = '0;
        sa_icb_cmd_read  = 1'b0;
        sa_icb_cmd_len   = '0;
        sa_icb_cmd_wdata = '0;
        sa_icb_cmd_wmask = '0;
        sa_icb_w_valid   = 1'b0;
        sa_icb_rsp_ready = 1'b0;

        up_cmd_ready     = 1'b0;
        up_w_ready       = 1'b0;
        up_rsp_valid     = 1'b0;
        up_rsp_rdata     = '0;
        up_rsp_err       = 1'b0;

        unique case (state_reg)
            ARB_IDLE: begin
                // Commit the pick; no handshake is offered this cycle.
                if (|grant) begin
                    owner_next   = grant[1];
                    rr_last_next = grant[1];
                    state_next   = ARB_CMD;
                end
            end

            ARB_CMD: begin
                sa_icb_cmd_valid = own_cmd.valid;
                sa_icb_cmd_addr  = own_cmd.addr;
                sa_icb_cmd_read  = own_cmd.read;
                sa_icb_cmd_len   = own_cmd.len;
                up_cmd_ready     = sa_icb_cmd_ready;
                // A master that withdraws its command simply keeps us here.
                if (cmd_fire) begin
                    is_read_next  = own_cmd.read;
                    len_q_next    = own_cmd.len;
                    beat_cnt_next = '0;
                    state_next    = own_cmd.read ? ARB_RSP : ARB_WDATA;
                end
            end

            ARB_WDATA: begin
                sa_icb_w_valid   = own_wr.w_valid;
                sa_icb_cmd_wdata = own_wr.wdata;
                sa_icb_cmd_wmask = own_wr.wmask;
                up_w_ready       = sa_icb_w_ready;
                if (w_fire) begin
                    if (is_last_beat(beat_cnt_reg, len_q_reg)) begin
                        beat_cnt_next = '0;
                        state_next    = ARB_RSP;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            ARB_RSP: begin
                up_rsp_valid     = sa_icb_rsp_valid;
                up_rsp_rdata     = sa_icb_rsp_rdata;
                up_rsp_err       = sa_icb_rsp_err;
                sa_icb_rsp_ready = own_rsp.rsp_ready;
                // Reads return len+1 beats, writes a single ack; errors
                // do not cut the burst short.
                if (rsp_fire) begin
                    if (!is_read_reg || is_last_beat(beat_cnt_reg, len_q_reg)) begin
                        beat_cnt_next = '0;
                        state_next    = ARB_IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Route the return paths to the owner only; the other master sees zeros.
    generate
        for (gi = 0; gi < ARB_NMST; gi++) begin : g_route
            logic sel;
            assign sel = (owner_reg == 1'(gi));

            assign cmd_s_arr[gi].ready     = sel & up_cmd_ready;
            assign wr_s_arr[gi].w_ready    = sel & up_w_ready;
            assign rsp_s_arr[gi].rsp_valid = sel & up_rsp_valid;
            assign rsp_s_arr[gi].rsp_rdata = sel ? up_rsp_rdata : '0;
            assign rsp_s_arr[gi].rsp_err   = sel & up_rsp_err;
        end
    endgenerate

    // State, ownership and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            owner_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            beat_cnt_reg <= '0;
            is_read_reg  <= 1'b0;
            len_q_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_last_reg  <= rr_last_next;
            beat_cnt_reg <= beat_cnt_next;
            is_read_reg  <= is_read_next;
            len_q_reg    <= len_q_next;
        end
    end

endmodule

// File: tb/tb_icb_ext_sram_arbiter.sv
// Bench for icb_ext_sram_arbiter: two master drivers, a downstream SRAM
// model with optional random stalls, a vector table and corner sequences.
module tb_icb_ext_sram_arbiter;
    import icb_ext_sram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icb_ext_sram_arbiter_if m0_if ();
    icb_ext_sram_arbiter_if m1_if ();

    icb_ext_cmd_m_t cmd_m [2];
    icb_ext_wr_m_t  wr_m  [2];
    icb_ext_rsp_m_t rsp_m [2];
    icb_ext_cmd_s_t cmd_s [2];
    icb_ext_wr_s_t  wr_s  [2];
    icb_ext_rsp_s_t rsp_s [2];

    assign m0_if.cmd_m = cmd_m[0];
    assign m1_if.cmd_m = cmd_m[1];
    assign m0_if.wr_m  = wr_m[0];
    assign m1_if.wr_m  = wr_m[1];
    assign m0_if.rsp_m = rsp_m[0];
    assign m1_if.rsp_m = rsp_m[1];
    assign cmd_s[0] = m0_if.cmd_s;
    assign cmd_s[1] = m1_if.cmd_s;
    assign wr_s[0]  = m0_if.wr_s;
    assign wr_s[1]  = m1_if.wr_s;
    assign rsp_s[0] = m0_if.rsp_s;
    assign rsp_s[1] = m1_if.rsp_s;

    logic        sa_icb_cmd_valid, sa_icb_cmd_ready;
    logic [18:0] sa_icb_cmd_addr;
    logic        sa_icb_cmd_read;
    logic [2:0]  sa_icb_cmd_len;
    logic [31:0] sa_icb_cmd_wdata;
    logic [3:0]  sa_icb_cmd_wmask;
    logic        sa_icb_w_valid, sa_icb_w_ready;
    logic        sa_icb_rsp_valid, sa_icb_rsp_ready;
    logic [31:0] sa_icb_rsp_rdata;
    logic        sa_icb_rsp_err;

    icb_ext_sram_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .m0               (m0_if),
        .m1               (m1_if),
        .sa_icb_cmd_valid (sa_icb_cmd_valid),
        .sa_icb_cmd_ready (sa_icb_cmd_ready),
        .sa_icb_cmd_addr  (sa_icb_cmd_addr),
        .sa_icb_cmd_read  (sa_icb_cmd_read),
        .sa_icb_cmd_len   (sa_icb_cmd_len),
        .sa_icb_cmd_wdata (sa_icb_cmd_wdata),
        .sa_icb_cmd_wmask (sa_icb_cmd_wmask),
        .sa_icb_w_valid   (sa_icb_w_valid),
        .sa_icb_w_ready   (sa_icb_w_ready),
        .sa_icb_rsp_valid (sa_icb_rsp_valid),
        .sa_icb_rsp_ready (sa_icb_rsp_ready),
        .sa_icb_rsp_rdata (sa_icb_rsp_rdata),
        .sa_icb_rsp_err   (sa_icb_rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- downstream SRAM model ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_ent_t;

    logic [31:0] mem [int];
    rsp_ent_t    rq [$];
    int          grant_log [$];
    int          wr_left;
    int          wr_addr;
    logic        wr_err;
    logic [18:0] last_cmd_addr;
    bit          stall_en;
    bit          early_rsp;
    int          quiet_viol;
    bit          expect_rsp [2];

    function automatic logic [31:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Addresses with bit 18 set answer with rsp_err=1.
    initial begin
        sa_icb_cmd_ready = 1'b0;
        sa_icb_w_ready   = 1'b0;
        sa_icb_rsp_valid = 1'b0;
        sa_icb_rsp_rdata = '0;
        sa_icb_rsp_err   = 1'b0;
        wr_left = 0;
        wr_addr = 0;
        wr_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq.delete();
                wr_left = 0;
                sa_icb_cmd_ready = 1'b0;
                sa_icb_w_ready   = 1'b0;
            end else begin
                sa_icb_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                sa_icb_w_ready   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!rst && rq.size() > 0) begin
                sa_icb_rsp_valid = 1'b1;
                sa_icb_rsp_rdata = rq[0].rdata;
                sa_icb_rsp_err   = rq[0].err;
            end else if (early_rsp) begin
                sa_icb_rsp_valid = 1'b1;
                sa_icb_rsp_rdata = 32'hDEAD_BEEF;
                sa_icb_rsp_err   = 1'b1;
            end else begin
                sa_icb_rsp_valid = 1'b0;
                sa_icb_rsp_rdata = '0;
                sa_icb_rsp_err   = 1'b0;
            end
            #1;
            if (!rst) begin
                if (sa_icb_cmd_valid && sa_icb_cmd_ready) begin
                    grant_log.push_back(cmd_s[1].ready ? 1 : 0);
                    last_cmd_addr = sa_icb_cmd_addr;
                    if (sa_icb_cmd_read) begin
                        for (int i = 0; i <= int'(sa_icb_cmd_len); i++)
                            rq.push_back('{rdata: mem_rd(int'(sa_icb_cmd_addr) + i),
                                           err: sa_icb_cmd_addr[18]});
                    end else begin
                        wr_left = int'(sa_icb_cmd_len) + 1;
                        wr_addr = int'(sa_icb_cmd_addr);
                        wr_err  = sa_icb_cmd_addr[18];
                    end
                end
                if (sa_icb_w_valid && sa_icb_w_ready && wr_left > 0) begin
                    mem[wr_addr] = sa_icb_cmd_wdata;
                    wr_addr++;
                    wr_left--;
                    if (wr_left == 0) rq.push_back('{rdata: 32'h0, err: wr_err});
                end
                if (sa_icb_rsp_valid && sa_icb_rsp_ready && rq.size() > 0)
                    void'(rq.pop_front());
            end
        end
    end

    // A master must never see rsp_valid unless it is collecting responses.
    initial begin
        quiet_viol = 0;
        forever begin
            @(negedge clk);
            #2;
            for (int m = 0; m < 2; m++)
                if (rsp_s[m].rsp_valid && !expect_rsp[m]) quiet_viol++;
        end
    end

    // ---------------- master driver ----------------
    // Must be called at a negedge; returns at the negedge after the last rsp.
    task automatic run_txn(input int m, input bit rd, input logic [18:0] addr,
                           input logic [2:0] len, input logic [31:0] d0,
                           input logic [31:0] step, input bit exp_err);
        int budget;
        bit fired;
        int nbeats;
        int got;
        cmd_m[m] = '{valid: 1'b1, addr: addr, read: rd, len: len};
        fired = 1'b0;
        budget = 0;
        while (!fired && budget < 300) begin
            #1;
            fired = cmd_s[m].ready;
            @(negedge clk);
            budget++;
        end
        cmd_m[m] = '0;
        if (!fired) begin
            chk($sformatf("m%0d_cmd_timeout", m), 64'd0, 64'd1);
            return;
        end
        if (!rd) begin
            for (int i = 0; i <= int'(len); i++) begin
                wr_m[m] = '{w_valid: 1'b1, wdata: d0 + 32'(i) * step, wmask: 4'hF};
                fired = 1'b0;
                budget = 0;
                while (!fired && budget < 300) begin
                    #1;
                    fired = wr_s[m].w_ready;
                    @(negedge clk);
                    budget++;
                end
                if (!fired) begin
                    wr_m[m] = '0;
                    chk($sformatf("m%0d_w_timeout", m), 64'd0, 64'd1);
                    return;
                end
            end
            wr_m[m] = '0;
        end
        expect_rsp[m] = 1'b1;
        nbeats = rd ? int'(len) + 1 : 1;
        got = 0;
        budget = 0;
        while (got < nbeats && budget < 400) begin
            rsp_m[m].rsp_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rsp_s[m].rsp_valid && rsp_m[m].rsp_ready) begin
                if (rd) chk($sformatf("m%0d_rdata_%0d", m, got), rsp_s[m].rsp_rdata,
                            d0 + 32'(got) * step);
                chk($sformatf("m%0d_rsp_err_%0d", m, got), rsp_s[m].rsp_err, exp_err);
                got++;
            end
            @(negedge clk);
            budget++;
        end
        rsp_m[m] = '0;
        expect_rsp[m] = 1'b0;
        chk($sformatf("m%0d_rsp_count", m), got, nbeats);
        $display("TXN m%0d %s addr=0x%0h len=%0d beats=%0d", m, rd ? "RD" : "WR",
                 addr, len, got);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          mst;
        bit          rd;
        logic [18:0] addr;
        logic [2:0]  len;
        logic [31:0] d0;
        logic [31:0] step;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b1, 19'h00100, 3'd3, 32'hA0,    32'h1,  1'b0};
        vecs[1] = '{1, 1'b0, 19'h00200, 3'd1, 32'h11,    32'h11, 1'b0};
        vecs[2] = '{1, 1'b1, 19'h00200, 3'd1, 32'h11,    32'h11, 1'b0};
        vecs[3] = '{0, 1'b0, 19'h00300, 3'd7, 32'h1000,  32'h1,  1'b0};
        vecs[4] = '{0, 1'b1, 19'h00300, 3'd7, 32'h1000,  32'h1,  1'b0};
        vecs[5] = '{1, 1'b1, 19'h00100, 3'd0, 32'hA0,    32'h1,  1'b0};
        vecs[6] = '{0, 1'b1, 19'h40000, 3'd1, 32'h55,    32'h11, 1'b1};
        vecs[7] = '{1, 1'b0, 19'h40010, 3'd0, 32'h9,     32'h0,  1'b1};

        for (int i = 0; i < 4; i++) mem[32'h100 + i] = 32'hA0 + 32'(i);
        mem[32'h40000] = 32'h55;
        mem[32'h40001] = 32'h66;

        for (int m = 0; m < 2; m++) begin
            cmd_m[m] = '0;
            wr_m[m]  = '0;
            rsp_m[m] = '0;
            expect_rsp[m] = 1'b0;
        end
        stall_en  = 1'b0;
        early_rsp = 1'b1;
        rst = 1'b1;

        // Reset state, with a stray downstream response being offered.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_valid", sa_icb_cmd_valid, 1'b0);
        chk("rst_w_valid", sa_icb_w_valid, 1'b0);
        chk("rst_rsp_ready", sa_icb_rsp_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("idle_cmd_addr", sa_icb_cmd_addr, 19'h0);
        chk("idle_wdata", sa_icb_cmd_wdata, 32'h0);
        chk("idle_rsp_ready", sa_icb_rsp_ready, 1'b0);
        chk("idle_m0_rsp_valid", rsp_s[0].rsp_valid, 1'b0);
        chk("idle_m0_rsp_rdata", rsp_s[0].rsp_rdata, 32'h0);
        chk("idle_m1_rsp_valid", rsp_s[1].rsp_valid, 1'b0);
        chk("idle_m0_cmd_ready", cmd_s[0].ready, 1'b0);
        early_rsp = 1'b0;
        @(negedge clk);
        quiet_viol = 0;

        // Tie right after reset: m0 first, one cycle of arbitration.
        grant_log.delete();
        fork
            run_txn(0, 1'b1, 19'h100, 3'd3, 32'hA0, 32'h1, 1'b0);
            run_txn(1, 1'b1, 19'h100, 3'd0, 32'hA0, 32'h1, 1'b0);
            begin
                #2;
                chk("arb_cycle_m0_ready", cmd_s[0].ready, 1'b0);
                chk("arb_cycle_cmd_valid", sa_icb_cmd_valid, 1'b0);
                @(negedge clk);
                #2;
                chk("grant_m0_ready", cmd_s[0].ready, 1'b1);
                chk("grant_m1_blocked", cmd_s[1].ready, 1'b0);
                chk("grant_cmd_addr", sa_icb_cmd_addr, 19'h100);
            end
        join
        chk("tie_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("tie_first", grant_log[0], 0);
            chk("tie_second", grant_log[1], 1);
        end
        chk("tie_nonowner_quiet", quiet_viol, 0);

        // Directed vector table with random downstream and master stalls.
        stall_en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            grant_log.delete();
            run_txn(vecs[v].mst, vecs[v].rd, vecs[v].addr, vecs[v].len,
                    vecs[v].d0, vecs[v].step, vecs[v].exp_err);
            chk($sformatf("vec%0d_owner", v),
                (grant_log.size() == 1) ? grant_log[0] : -1, vecs[v].mst);
            chk($sformatf("vec%0d_cmd_addr", v), last_cmd_addr, vecs[v].addr);
        end
        chk("table_nonowner_quiet", quiet_viol, 0);

        // m0 back-to-back while m1 waits: m0, m1, m0.
        grant_log.delete();
        fork
            begin
                run_txn(0, 1'b1, 19'h100, 3'd1, 32'hA0, 32'h1, 1'b0);
                run_txn(0, 1'b1, 19'h102, 3'd1, 32'hA2, 32'h1, 1'b0);
            end
            begin
                @(negedge clk);
                run_txn(1, 1'b1, 19'h200, 3'd1, 32'h11, 32'h11, 1'b0);
            end
        join
        chk("b2b_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("b2b_first", grant_log[0], 0);
            chk("b2b_second", grant_log[1], 1);
            chk("b2b_third", grant_log[2], 0);
        end
        chk("b2b_nonowner_quiet", quiet_viol, 0);

        // Reset in the middle of a len=7 write.
        stall_en = 1'b0;
        cmd_m[0] = '{valid: 1'b1, addr: 19'h500, read: 1'b0, len: 3'd7};
        wr_m[0]  = '{w_valid: 1'b1, wdata: 32'h77, wmask: 4'hF};
        begin
            int budget;
            bit fired;
            budget = 0;
            fired = 1'b0;
            while (!fired && budget < 20) begin
                #1;
                fired = cmd_s[0].ready;
                @(negedge clk);
                budget++;
            end
            chk("midrst_cmd_accepted", fired, 1'b1);
        end
        cmd_m[0] = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("midrst_in_wdata", sa_icb_w_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_w_valid", sa_icb_w_valid, 1'b0);
        chk("midrst_cmd_valid", sa_icb_cmd_valid, 1'b0);
        chk("midrst_m0_w_ready", wr_s[0].w_ready, 1'b0);
        chk("midrst_rsp_ready", sa_icb_rsp_ready, 1'b0);
        wr_m[0] = '0;
        rst = 1'b0;
        @(negedge clk);
        grant_log.delete();
        run_txn(0, 1'b1, 19'h100, 3'd3, 32'hA0, 32'h1, 1'b0);
        chk("post_rst_owner", (grant_log.size() == 1) ? grant_log[0] : -1, 0);
        chk("final_nonowner_quiet", quiet_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
